// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank: counting modes,
// the event index map used by the cpu/mem_hierarchy strobes, and index sizing.
package perf_pkg;

    typedef enum logic {
        CNT_LEVEL = 1'b0,
        CNT_EDGE  = 1'b1
    } cnt_mode_e;

    localparam int EV_COMMIT   = 0;
    localparam int EV_BR       = 1;
    localparam int EV_BR_OK    = 2;
    localparam int EV_JMP      = 3;
    localparam int EV_IHIT     = 4;
    localparam int EV_IMISS    = 5;
    localparam int EV_DHIT     = 6;
    localparam int EV_DMISS    = 7;
    localparam int EV_L2HIT    = 8;
    localparam int EV_L2MISS   = 9;
    localparam int EV_STALL_I  = 10;
    localparam int EV_STALL_D  = 11;
    localparam int EV_STALL_BR = 12;
    localparam int EV_STALL_LU = 13;
    localparam int EV_PF_REQ   = 14;
    localparam int EV_PF_EX    = 15;
    localparam int NUM_EV      = 16;

    // Index width for n counters; a single counter still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One performance counter: level/edge event qualification, wrap or saturate on
// overflow, sticky overflow flag, per-counter mode bit and snapshot shadow.
module perf_counter_slice
    import perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int INC_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             snap,
    input  logic [INC_W-1:0] inc,
    input  logic             cfg_we,
    input  logic             cfg_edge,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    localparam int SUM_W = CNT_W + 1;

    cnt_mode_e        mode;
    logic             prev;
    logic             inc_nz;
    logic             rise;
    logic [SUM_W-1:0] step;
    logic [SUM_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_nxt;

    assign inc_nz = |inc;
    assign rise   = inc_nz & ~prev;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        step = '0;
        if (en) begin
            step = (mode == CNT_EDGE) ? SUM_W'(rise) : SUM_W'(inc);
        end
        sum     = SUM_W'(cnt) + step;
        carry   = sum[CNT_W];
        cnt_nxt = sum[CNT_W-1:0];
        // The carry also fires for all-ones plus any non-zero step, so it covers that case too.
        if (carry && (SATURATE != 0)) begin
            cnt_nxt = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            // NOTE: the shadow is a plain register bank, not a RAM, so it resets with everything else.
            shadow <= '0;
            ovf    <= 1'b0;
            mode   <= CNT_LEVEL;
            prev   <= 1'b0;
        end else begin
            prev <= inc_nz;
            if (cfg_we) begin
                mode <= cnt_mode_e'(cfg_edge);
            end
            if (snap) begin
                shadow <= cnt;
            end
            if (clear) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                cnt <= cnt_nxt;
                if (carry) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters for cpu/cache statistics, with mode config
// decode and a registered one-cycle read port over live or shadow values.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CNT  = 16,
    parameter int CNT_W    = 32,
    parameter int INC_W    = 2,
    parameter int SATURATE = 0,
    parameter int IDX_W    = idx_width(NUM_CNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     snap,
    input  logic [NUM_CNT*INC_W-1:0] evt_inc,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic                     cfg_edge,
    input  logic                     rd_req,
    input  logic [IDX_W-1:0]         rd_idx,
    input  logic                     rd_shadow,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     rd_err,
    output logic [NUM_CNT-1:0]       ovf
);

    logic [CNT_W-1:0] cnt    [NUM_CNT];
    logic [CNT_W-1:0] shadow [NUM_CNT];
    logic             rd_ok;
    logic [CNT_W-1:0] rd_mux;

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_slice
        // An out-of-range cfg_idx matches no slice, so the write is dropped.
        perf_counter_slice #(
            .CNT_W    (CNT_W),
            .INC_W    (INC_W),
            .SATURATE (SATURATE)
        ) u_slice (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clear    (clear),
            .snap     (snap),
            .inc      (evt_inc[gi*INC_W +: INC_W]),
            .cfg_we   (cfg_we && (cfg_idx == IDX_W'(gi))),
            .cfg_edge (cfg_edge),
            .cnt      (cnt[gi]),
            .shadow   (shadow[gi]),
            .ovf      (ovf[gi])
        );
    end

    // Reads see the registered counters, i.e. the value before this cycle's update.
    always_comb begin
        rd_ok  = (int'(rd_idx) < NUM_CNT);
        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_mux = rd_shadow ? shadow[i] : cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
                rd_err  <= ~rd_ok;
            end else begin
                rd_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: a 4-counter wrapping bank and a 5-counter saturating bank
// driven by the same stimulus; expected reads are queued at issue time.
module tb_perf_counter_bank;

    localparam int NA = 4;
    localparam int NB = 5;
    localparam int CW = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst, en, clear, snap, cfg_we, cfg_edge, rd_req, rd_shadow;
    logic [NA*IW-1:0] evt;
    logic [NB*IW-1:0] evt_b;
    logic [2:0]       cfg_idx, rd_idx;

    logic          rd_valid_a, rd_err_a, rd_valid_b, rd_err_b;
    logic [CW-1:0] rd_data_a, rd_data_b;
    logic [NA-1:0] ovf_a;
    logic [NB-1:0] ovf_b;

    assign evt_b = {{IW{1'b0}}, evt};

    perf_counter_bank #(.NUM_CNT(NA), .CNT_W(CW), .INC_W(IW), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .snap(snap), .evt_inc(evt),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx[1:0]), .cfg_edge(cfg_edge),
        .rd_req(rd_req), .rd_idx(rd_idx[1:0]), .rd_shadow(rd_shadow),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_err(rd_err_a), .ovf(ovf_a)
    );

    perf_counter_bank #(.NUM_CNT(NB), .CNT_W(CW), .INC_W(IW), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .snap(snap), .evt_inc(evt_b),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_edge(cfg_edge),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_err(rd_err_b), .ovf(ovf_b)
    );

    typedef struct {
        int            cyc;
        string         tag;
        logic [CW-1:0] da;
        logic [CW-1:0] db;
        logic          eb;
    } rd_exp_t;

    rd_exp_t       sb[$];
    rd_exp_t       mon_e;
    bit            mon_v;
    bit            mon_en = 1'b1;
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [CW-1:0] last_a = '0;
    logic [CW-1:0] last_b = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(input int i, input logic [IW-1:0] v);
        evt[i*IW +: IW] = v;
    endtask

    task automatic rd(input int idx, input bit sh, input logic [CW-1:0] ea,
                      input logic [CW-1:0] eb, input bit err_b, input string tag);
        rd_exp_t e;
        rd_req    = 1'b1;
        rd_idx    = 3'(idx);
        rd_shadow = sh;
        e.cyc = cyc;
        e.tag = tag;
        e.da  = ea;
        e.db  = eb;
        e.eb  = err_b;
        sb.push_back(e);
        tick();
        rd_req = 1'b0;
    endtask

    // Every cycle: rd_valid must match the scoreboard; data holds when no read returns.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_v = (sb.size() != 0) && (sb[0].cyc + 1 == cyc);
            check("rd_valid_a", 64'(rd_valid_a), 64'(mon_v));
            check("rd_valid_b", 64'(rd_valid_b), 64'(mon_v));
            if (mon_v) begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_data_a"}, 64'(rd_data_a), 64'(mon_e.da));
                check({mon_e.tag, "_data_b"}, 64'(rd_data_b), 64'(mon_e.db));
                check({mon_e.tag, "_err_a"}, 64'(rd_err_a), 64'd0);
                check({mon_e.tag, "_err_b"}, 64'(rd_err_b), 64'(mon_e.eb));
                last_a = mon_e.da;
                last_b = mon_e.db;
            end else begin
                check("hold_a", 64'(rd_data_a), 64'(last_a));
                check("hold_b", 64'(rd_data_b), 64'(last_b));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid_a"}, 64'(rd_valid_a), 64'd0);
        check({tag, "_valid_b"}, 64'(rd_valid_b), 64'd0);
        check({tag, "_data_a"}, 64'(rd_data_a), 64'd0);
        check({tag, "_data_b"}, 64'(rd_data_b), 64'd0);
        check({tag, "_err_a"}, 64'(rd_err_a), 64'd0);
        check({tag, "_err_b"}, 64'(rd_err_b), 64'd0);
        check({tag, "_ovf_a"}, 64'(ovf_a), 64'd0);
        check({tag, "_ovf_b"}, 64'(ovf_b), 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; snap = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_edge = 1'b0;
        rd_req = 1'b0; rd_idx = '0; rd_shadow = 1'b0; evt = '0;
        #1 rst = 1'b0;
        #1 check_idle_outputs("reset");
        #10 rst = 1'b1;
        tick();

        // Level count: counter 1 at +2 for 10 cycles.
        en = 1'b1;
        set_inc(1, 2'd2);
        repeat (10) tick();
        set_inc(1, 2'd0);
        en = 1'b0;
        rd(0, 1'b0, 8'd0, 8'd0, 1'b0, "lvl0");
        rd(1, 1'b0, 8'd20, 8'd20, 1'b0, "lvl1");
        rd(2, 1'b0, 8'd0, 8'd0, 1'b0, "lvl2");
        rd(3, 1'b0, 8'd0, 8'd0, 1'b0, "lvl3");
        rd(4, 1'b0, 8'd0, 8'd0, 1'b0, "lvl4");
        tick();
        check("lvl_ovf_a", 64'(ovf_a), 64'd0);

        // Edge mode on counter 2: two rises while enabled.
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_edge = 1'b1;
        tick();
        cfg_we = 1'b0;
        en = 1'b1;
        set_inc(2, 2'd1);
        repeat (5) tick();
        set_inc(2, 2'd0);
        repeat (2) tick();
        set_inc(2, 2'd1);
        repeat (2) tick();
        set_inc(2, 2'd0);
        en = 1'b0;
        tick();
        rd(2, 1'b0, 8'd2, 8'd2, 1'b0, "edge2");

        // First rise with en=0 is lost; only the second counts.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_inc(2, 2'd1);
        tick();
        en = 1'b1;
        repeat (3) tick();
        set_inc(2, 2'd0);
        tick();
        set_inc(2, 2'd1);
        tick();
        set_inc(2, 2'd0);
        en = 1'b0;
        tick();
        rd(2, 1'b0, 8'd1, 8'd1, 1'b0, "edge_en");
        rd(1, 1'b0, 8'd0, 8'd0, 1'b0, "cleared1");

        // Overflow: 254 then +3 wraps to 1 (A) or clamps at 255 (B).
        en = 1'b1;
        set_inc(0, 2'd2);
        repeat (127) tick();
        check("pre_ovf_a", 64'(ovf_a), 64'd0);
        check("pre_ovf_b", 64'(ovf_b), 64'd0);
        set_inc(0, 2'd3);
        tick();
        set_inc(0, 2'd0);
        en = 1'b0;
        rd(0, 1'b0, 8'd1, 8'd255, 1'b0, "ovf0");
        check("ovf_a", 64'(ovf_a), 64'b0001);
        check("ovf_b", 64'(ovf_b), 64'b00001);
        en = 1'b1;
        set_inc(0, 2'd1);
        tick();
        set_inc(0, 2'd0);
        en = 1'b0;
        repeat (3) tick();
        rd(0, 1'b0, 8'd2, 8'd255, 1'b0, "sat0");
        check("sticky_a", 64'(ovf_a), 64'b0001);
        check("sticky_b", 64'(ovf_b), 64'b00001);

        // Snap and clear together capture the old values.
        en = 1'b1;
        set_inc(3, 2'd1);
        repeat (37) tick();
        set_inc(3, 2'd0);
        en = 1'b0;
        snap = 1'b1; clear = 1'b1;
        tick();
        snap = 1'b0; clear = 1'b0;
        check("snapclr_ovf_a", 64'(ovf_a), 64'd0);
        check("snapclr_ovf_b", 64'(ovf_b), 64'd0);
        rd(3, 1'b0, 8'd0, 8'd0, 1'b0, "live3");
        rd(3, 1'b1, 8'd37, 8'd37, 1'b0, "shadow3");
        rd(5, 1'b0, 8'd0, 8'd0, 1'b1, "err5");
        rd(0, 1'b1, 8'd2, 8'd255, 1'b0, "shadow0");
        rd(2, 1'b1, 8'd1, 8'd1, 1'b0, "shadow2");
        tick();

        // cfg_idx 5 is out of range for B; A decodes it as counter 1.
        cfg_we = 1'b1; cfg_idx = 3'd5; cfg_edge = 1'b1;
        tick();
        cfg_we = 1'b0;
        en = 1'b1;
        set_inc(1, 2'd1);
        repeat (3) tick();
        set_inc(1, 2'd0);
        en = 1'b0;
        rd(1, 1'b0, 8'd1, 8'd3, 1'b0, "cfg_oor");
        repeat (2) tick();

        // Async reset while counting with a read in flight.
        mon_en = 1'b0;
        en = 1'b1;
        set_inc(0, 2'd1);
        rd_req = 1'b1; rd_idx = 3'd0; rd_shadow = 1'b0;
        tick();
        rst = 1'b0;
        #1 check_idle_outputs("midrst");
        rd_req = 1'b0; en = 1'b0; evt = '0;
        #20 rst = 1'b1;
        last_a = '0;
        last_b = '0;
        tick();
        mon_en = 1'b1;
        repeat (3) tick();

        // Modes are level again after reset.
        en = 1'b1;
        set_inc(1, 2'd1);
        set_inc(2, 2'd1);
        repeat (3) tick();
        evt = '0;
        en = 1'b0;
        rd(1, 1'b0, 8'd3, 8'd3, 1'b0, "postrst1");
        rd(2, 1'b0, 8'd3, 8'd3, 1'b0, "postrst2");
        rd(0, 1'b0, 8'd0, 8'd0, 1'b0, "postrst0");

        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
